// File: rtl/contador_ocupacao_if.sv
// Occupancy counter bus: door sensor and buttons in, count/status flags out.
interface contador_ocupacao_if #(
    parameter int unsigned CNT_W = 3
);
    logic             P;
    logic             btn_in_n;
    logic             btn_out_n;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             reject;
    logic             door_alarm;

    modport master (
        output P, btn_in_n, btn_out_n,
        input  count, full, empty, reject, door_alarm
    );

    modport slave (
        input  P, btn_in_n, btn_out_n,
        output count, full, empty, reject, door_alarm
    );
endinterface

// File: rtl/contador_ocupacao.sv
// Room/lift occupancy counter: synchronised active-low buttons gated by the door sensor.
// Optional door-open timeout alarm built when macro DOOR_TIMEOUT_EN is defined.
module contador_ocupacao #(
    parameter int unsigned CAPACITY     = 7,
    parameter int unsigned CNT_W        = 3,
    parameter int unsigned DOOR_TIMEOUT = 10
) (
    input  logic                clk,
    input  logic                reset,
    contador_ocupacao_if.slave  bus
);

    localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);
    localparam int unsigned      TMR_W    = (DOOR_TIMEOUT > 1) ? $clog2(DOOR_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DOOR_TIMEOUT - 1);

    // Synchronisers; buttons reset to the released level so no spurious press appears
    logic p_s1, p_s2;
    logic in_s1, in_s2, in_prev;
    logic out_s1, out_s2, out_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            p_s1     <= 1'b0;
            p_s2     <= 1'b0;
            in_s1    <= 1'b1;
            in_s2    <= 1'b1;
            in_prev  <= 1'b1;
            out_s1   <= 1'b1;
            out_s2   <= 1'b1;
            out_prev <= 1'b1;
        end else begin
            p_s1     <= bus.P;
            p_s2     <= p_s1;
            in_s1    <= bus.btn_in_n;
            in_s2    <= in_s1;
            in_prev  <= in_s2;
            out_s1   <= bus.btn_out_n;
            out_s2   <= out_s1;
            out_prev <= out_s2;
        end
    end

    logic door_ok;
    logic press_in;
    logic press_out;

    assign door_ok   = p_s2;
    assign press_in  = in_prev & ~in_s2;
    assign press_out = out_prev & ~out_s2;

    // Saturating occupancy update
    logic [CNT_W-1:0] count_r, count_next;
    logic             reject_r, reject_next;

    always_comb begin
        count_next  = count_r;
        reject_next = 1'b0;
        if (door_ok) begin
            if (press_in && !press_out) begin
                if (count_r < CAP) begin
                    count_next = count_r + CNT_W'(1);
                end else begin
                    reject_next = 1'b1;
                end
            end else if (press_out && !press_in) begin
                if (count_r != '0) begin
                    count_next = count_r - CNT_W'(1);
                end else begin
                    reject_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_r  <= '0;
            reject_r <= 1'b0;
        end else begin
            count_r  <= count_next;
            reject_r <= reject_next;
        end
    end

    assign bus.count  = count_r;
    assign bus.full   = (count_r == CAP);
    assign bus.empty  = (count_r == '0);
    assign bus.reject = reject_r;

`ifdef DOOR_TIMEOUT_EN
    typedef enum logic [1:0] {
        ST_CLOSED = 2'd0,
        ST_OPEN   = 2'd1,
        ST_ALARM  = 2'd2
    } door_state_t;

    door_state_t      state_r, state_next;
    logic [TMR_W-1:0] timer_r, timer_next;
    logic             alarm_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_CLOSED;
            timer_r <= '0;
            alarm_r <= 1'b0;
        end else begin
            state_r <= state_next;
            timer_r <= timer_next;
            alarm_r <= (state_next == ST_ALARM);
        end
    end

    // Timer never steps past TMR_LAST: entering ALARM freezes it there
    always_comb begin
        state_next = state_r;
        timer_next = timer_r;
        case (state_r)
            ST_CLOSED: begin
                timer_next = '0;
                if (door_ok) state_next = ST_OPEN;
            end
            ST_OPEN: begin
                if (!door_ok) begin
                    state_next = ST_CLOSED;
                end else if (timer_r == TMR_LAST) begin
                    state_next = ST_ALARM;
                end else begin
                    timer_next = timer_r + TMR_W'(1);
                end
            end
            ST_ALARM: begin
                if (!door_ok) state_next = ST_CLOSED;
            end
            default: begin
                state_next = ST_CLOSED;
                timer_next = '0;
            end
        endcase
    end

    assign bus.door_alarm = alarm_r;
`else
    typedef enum logic {
        ST_CLOSED = 1'b0,
        ST_OPEN   = 1'b1
    } door_state_t;

    door_state_t state_r, state_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_CLOSED;
        end else begin
            state_r <= state_next;
        end
    end

    always_comb begin
        state_next = state_r;
        case (state_r)
            ST_CLOSED: if (door_ok)  state_next = ST_OPEN;
            ST_OPEN:   if (!door_ok) state_next = ST_CLOSED;
            default:   state_next = ST_CLOSED;
        endcase
    end

    // Door state has no observer without the alarm; keep it visible but unused
    logic unused_door;
    assign unused_door = ^{state_r, TMR_LAST};

    assign bus.door_alarm = 1'b0;
`endif

endmodule
